// File: rtl/deskew_pkg.sv
// Shared types and helpers for the deskew collector: FSM state encoding,
// the default lane width and the beats-per-collection formula.
package deskew_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   localparam int DEF_LANE_W = 16;

   // Lane j of the last row arrives j beats late, so a collection needs DIM-1 extra beats.
   function automatic int beat_total(input int rows, input int dim);
      return rows + dim - 1;
   endfunction

endpackage

// File: rtl/deskew_collector_skid_buf2.sv
// Two-entry valid/ready buffer carrying a row word plus a last flag.
// o_occ is exported so the producer can throttle itself without looking at i_ready.
module skid_buf2 #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_push,
   input  logic [W-1:0] i_data,
   input  logic         i_last,
   input  logic         i_ready,
   output logic         o_valid,
   output logic [W-1:0] o_data,
   output logic         o_last,
   output logic [1:0]   o_occ
);

   logic [W-1:0] r_mem [2];
   logic         r_lst [2];
   logic         r_wr;
   logic         r_rd;
   logic [1:0]   r_occ;
   logic         w_push;
   logic         w_pop;

   assign w_pop  = o_valid && i_ready;
   assign w_push = i_push && (r_occ != 2'd2);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_mem[0] <= '0;
         r_mem[1] <= '0;
         r_lst[0] <= 1'b0;
         r_lst[1] <= 1'b0;
         r_wr     <= 1'b0;
         r_rd     <= 1'b0;
         r_occ    <= 2'd0;
      end else begin
         if (w_push) begin
            r_mem[r_wr] <= i_data;
            r_lst[r_wr] <= i_last;
            r_wr        <= ~r_wr;
         end
         if (w_pop) r_rd <= ~r_rd;
         case ({w_push, w_pop})
            2'b10:   r_occ <= r_occ + 2'd1;
            2'b01:   r_occ <= r_occ - 2'd1;
            default: r_occ <= r_occ;
         endcase
      end
   end

   assign o_valid = (r_occ != 2'd0);
   assign o_data  = r_mem[r_rd];
   assign o_last  = r_lst[r_rd];
   assign o_occ   = r_occ;

endmodule

// File: rtl/deskew_collector.sv
// Removes the per-lane stagger of a skewed row stream with beat-gated delay
// chains and hands whole aligned rows downstream through a 2-entry buffer.
module deskew_collector
   import deskew_pkg::*;
#(
   parameter int DIM   = 8,
   parameter int BITS  = DEF_LANE_W,
   parameter int ROW_W = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [ROW_W-1:0]    num_rows,
   input  logic                en,
   input  logic [DIM*BITS-1:0] d,
   output logic                in_rdy,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [DIM*BITS-1:0] out_data,
   output logic                out_last,
   output logic                busy,
   output logic                done
);

   localparam int BW = ROW_W + $clog2(DIM);

   state_t              r_state;
   logic [BW-1:0]       r_beat;
   logic [BW-1:0]       r_total;
   logic [ROW_W-1:0]    r_row;
   logic [ROW_W-1:0]    r_rows;
   logic                r_done;
   logic                w_start_acc;
   logic                w_beat_acc;
   logic                w_push;
   logic                w_final_beat;
   logic                w_row_last;
   logic [1:0]          w_occ;
   logic [DIM*BITS-1:0] w_row;

   // Throttling uses occupancy only, so in_rdy never combinationally depends on out_ready.
   assign in_rdy       = (r_state == RUN) && (w_occ != 2'd2);
   assign w_start_acc  = start && (r_state == IDLE);
   assign w_beat_acc   = en && in_rdy;
   assign w_push       = w_beat_acc && (r_beat >= BW'(DIM - 1));
   assign w_final_beat = w_beat_acc && (r_beat == r_total - BW'(1));
   assign w_row_last   = (r_row == r_rows - ROW_W'(1));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_beat  <= '0;
         r_total <= '0;
         r_row   <= '0;
         r_rows  <= '0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: if (start) begin
               r_beat  <= '0;
               r_row   <= '0;
               r_rows  <= num_rows;
               r_total <= BW'(beat_total(int'(num_rows), DIM));
               if (num_rows != '0) r_state <= RUN;
               else                r_done  <= 1'b1;
            end
            RUN: if (w_beat_acc) begin
               r_beat <= r_beat + BW'(1);
               if (w_push)       r_row   <= r_row + ROW_W'(1);
               if (w_final_beat) r_state <= DRAIN;
            end
            DRAIN: if (out_valid && out_ready && out_last) begin
               r_state <= IDLE;
               r_done  <= 1'b1;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // Lane j waits DIM-1-j accepted beats so that all lanes of a row meet at the chain heads.
   for (genvar j = 0; j < DIM - 1; j++) begin : g_lane
      localparam int L = DIM - 1 - j;
      logic [BITS-1:0] r_dly [L];

      always_ff @(posedge clk) begin
         if (!rst_n || w_start_acc) begin
            for (int i = 0; i < L; i++) r_dly[i] <= '0;
         end else if (w_beat_acc) begin
            r_dly[0] <= d[j*BITS +: BITS];
            for (int i = 1; i < L; i++) r_dly[i] <= r_dly[i-1];
         end
      end

      assign w_row[j*BITS +: BITS] = r_dly[L-1];
   end
   assign w_row[(DIM-1)*BITS +: BITS] = d[(DIM-1)*BITS +: BITS];

   skid_buf2 #(.W(DIM*BITS)) u_buf (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push),
      .i_data  (w_row),
      .i_last  (w_row_last),
      .i_ready (out_ready),
      .o_valid (out_valid),
      .o_data  (out_data),
      .o_last  (out_last),
      .o_occ   (w_occ)
   );

   assign busy = (r_state != IDLE);
   assign done = r_done;

endmodule

// File: tb/tb_deskew_collector.sv
// Bench for deskew_collector at DIM=4, BITS=8: skewed beats are built from a
// row table and emitted rows are compared with rows taken straight from that table.
module tb_deskew_collector;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [7:0]  num_rows;
   logic        en;
   logic [31:0] d;
   logic        in_rdy;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic        out_last;
   logic        busy;
   logic        done;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   logic [7:0]  row_lane [64][4];
   int          cur_n;
   logic [32:0] exp_q [$];
   logic [32:0] got_q [$];
   int          hs_cyc [$];
   int          beat_cyc [$];
   int          done_cnt;
   int          done_cyc;

   deskew_collector #(.DIM(4), .BITS(8), .ROW_W(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .num_rows  (num_rows),
      .en        (en),
      .d         (d),
      .in_rdy    (in_rdy),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Lane j of beat k belongs to row k-j; lanes outside the collection carry junk.
   function automatic logic [31:0] beat_word(input int k);
      logic [31:0] w;
      int r;
      for (int j = 0; j < 4; j++) begin
         r = k - j;
         if (r >= 0 && r < cur_n) w[j*8 +: 8] = row_lane[r][j];
         else                     w[j*8 +: 8] = 8'($urandom);
      end
      return w;
   endfunction

   task automatic set_rows(input int n, input bit rnd);
      cur_n = n;
      for (int r = 0; r < n; r++)
         for (int j = 0; j < 4; j++)
            row_lane[r][j] = rnd ? 8'($urandom) : 8'(8'h10 * r + j);
      exp_q.delete();
      for (int r = 0; r < n; r++)
         exp_q.push_back({(r == n - 1), row_lane[r][3], row_lane[r][2], row_lane[r][1], row_lane[r][0]});
   endtask

   task automatic clear_mon();
      got_q.delete();
      hs_cyc.delete();
      beat_cyc.delete();
      done_cnt = 0;
      done_cyc = -1;
   endtask

   task automatic start_coll(input int n);
      @(posedge clk); #1;
      start    = 1'b1;
      num_rows = 8'(n);
      @(posedge clk); #1;
      start    = 1'b0;
   endtask

   task automatic drive_beats(input int nbeats, input bit gap, output int nacc);
      int  tmo;
      bit  ph;
      bit  acc;
      nacc = 0;
      tmo  = 0;
      ph   = 1'b1;
      d    = beat_word(0);
      while (nacc < nbeats && tmo < 1000) begin
         en = gap ? ph : 1'b1;
         ph = ~ph;
         @(negedge clk);
         acc = en && in_rdy;
         @(posedge clk); #1;
         if (acc) begin
            nacc++;
            d = beat_word(nacc);
         end
         tmo++;
      end
      en = 1'b0;
   endtask

   task automatic wait_done(output bit ok);
      int t = 0;
      while (done_cnt == 0 && t < 300) begin
         @(negedge clk);
         t++;
      end
      repeat (3) @(negedge clk);
      ok = (done_cnt != 0);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++; if (in_rdy !== 1'b0)     begin errors++; $display("FAIL reset_in_rdy got %b exp 0", in_rdy); end
      checks++; if (out_valid !== 1'b0)  begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
      checks++; if (out_last !== 1'b0)   begin errors++; $display("FAIL reset_out_last got %b exp 0", out_last); end
      checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
      checks++; if (done !== 1'b0)       begin errors++; $display("FAIL reset_done got %b exp 0", done); end
      checks++; if (out_data !== 32'h0)  begin errors++; $display("FAIL reset_out_data got %h exp 0", out_data); end
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      int nacc;
      bit ok;
      out_ready = 1'b1;
      set_rows(4, 1'b0);
      clear_mon();
      start_coll(4);
      drive_beats(7, 1'b0, nacc);
      wait_done(ok);
      checks++; if (nacc !== 7) begin errors++; $display("FAIL basic_beats got %0d exp 7", nacc); end
      checks++; if (!ok) begin errors++; $display("FAIL basic_done_timeout got 0 exp 1"); end
      checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL basic_count got %0d exp %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL basic_row%0d got %h exp %h", i, got_q[i], exp_q[i]); end
      end
      if (hs_cyc.size() > 0 && beat_cyc.size() > 3) begin
         checks++;
         if (hs_cyc[0] != beat_cyc[3] + 1) begin errors++; $display("FAIL basic_latency got %0d exp %0d", hs_cyc[0], beat_cyc[3] + 1); end
      end
      if (hs_cyc.size() > 0) begin
         checks++;
         if (done_cyc != hs_cyc[hs_cyc.size()-1] + 1) begin errors++; $display("FAIL basic_done_cycle got %0d exp %0d", done_cyc, hs_cyc[hs_cyc.size()-1] + 1); end
      end
      checks++; if (done_cnt != 1) begin errors++; $display("FAIL basic_done_count got %0d exp 1", done_cnt); end
   endtask

   task automatic test_backpressure();
      int nacc;
      int unstable;
      bit ok;
      out_ready = 1'b0;
      set_rows(4, 1'b0);
      clear_mon();
      start_coll(4);
      unstable = 0;
      fork
         drive_beats(7, 1'b0, nacc);
         begin
            repeat (10) @(negedge clk);
            repeat (10) begin
               @(negedge clk);
               if (out_data !== 32'h03020100 || out_valid !== 1'b1) unstable++;
            end
            checks++; if (beat_cyc.size() != 5) begin errors++; $display("FAIL bp_beats_before_stall got %0d exp 5", beat_cyc.size()); end
            checks++; if (in_rdy !== 1'b0) begin errors++; $display("FAIL bp_in_rdy got %b exp 0", in_rdy); end
            checks++; if (unstable != 0) begin errors++; $display("FAIL bp_hold got %0d unstable cycles exp 0", unstable); end
            checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL bp_last got %b exp 0", out_last); end
            @(posedge clk); #1;
            out_ready = 1'b1;
         end
      join
      wait_done(ok);
      checks++; if (!ok) begin errors++; $display("FAIL bp_done_timeout got 0 exp 1"); end
      checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL bp_count got %0d exp %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL bp_row%0d got %h exp %h", i, got_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_gapped();
      int nacc;
      bit ok;
      out_ready = 1'b1;
      set_rows(4, 1'b0);
      clear_mon();
      start_coll(4);
      drive_beats(7, 1'b1, nacc);
      wait_done(ok);
      checks++; if (!ok) begin errors++; $display("FAIL gap_done_timeout got 0 exp 1"); end
      checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL gap_count got %0d exp %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL gap_row%0d got %h exp %h", i, got_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_zero();
      int bad;
      clear_mon();
      start_coll(0);
      en = 1'b1;
      @(negedge clk);
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL zero_done got %b exp 1", done); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zero_busy got %b exp 0", busy); end
      bad = 0;
      repeat (6) begin
         @(negedge clk);
         if (in_rdy !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0) bad++;
      end
      en = 1'b0;
      checks++; if (bad != 0) begin errors++; $display("FAIL zero_quiet got %0d bad cycles exp 0", bad); end
      checks++; if (done_cnt != 1) begin errors++; $display("FAIL zero_done_count got %0d exp 1", done_cnt); end
   endtask

   task automatic test_reset_mid();
      int nacc;
      bit ok;
      out_ready = 1'b0;
      set_rows(4, 1'b1);
      clear_mon();
      start_coll(4);
      drive_beats(5, 1'b0, nacc);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rmid_pre_valid got %b exp 1", out_valid); end
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_out_valid got %b exp 0", out_valid); end
      checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL rmid_busy got %b exp 0", busy); end
      checks++; if (in_rdy !== 1'b0)    begin errors++; $display("FAIL rmid_in_rdy got %b exp 0", in_rdy); end
      @(posedge clk); #1;
      rst_n     = 1'b1;
      out_ready = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (done_cnt != 0) begin errors++; $display("FAIL rmid_no_done got %0d exp 0", done_cnt); end
      cur_n = 1;
      for (int j = 0; j < 4; j++) row_lane[0][j] = 8'(8'hA0 + j);
      exp_q.delete();
      exp_q.push_back({1'b1, 32'hA3A2A1A0});
      clear_mon();
      start_coll(1);
      drive_beats(4, 1'b0, nacc);
      wait_done(ok);
      checks++; if (got_q.size() != 1) begin errors++; $display("FAIL rmid_count got %0d exp 1", got_q.size()); end
      if (got_q.size() > 0) begin
         checks++;
         if (got_q[0] !== exp_q[0]) begin errors++; $display("FAIL rmid_row got %h exp %h", got_q[0], exp_q[0]); end
      end
   endtask

   task automatic test_start_busy();
      int nacc;
      bit ok;
      out_ready = 1'b1;
      set_rows(3, 1'b1);
      clear_mon();
      start_coll(3);
      fork
         drive_beats(6, 1'b0, nacc);
         begin
            repeat (3) @(posedge clk);
            #1;
            start    = 1'b1;
            num_rows = 8'd7;
            @(posedge clk); #1;
            start    = 1'b0;
         end
      join
      en = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      en = 1'b0;
      wait_done(ok);
      checks++; if (beat_cyc.size() != 6) begin errors++; $display("FAIL busy_start_beats got %0d exp 6", beat_cyc.size()); end
      checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL busy_start_count got %0d exp %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL busy_start_row%0d got %h exp %h", i, got_q[i], exp_q[i]); end
      end
      checks++; if (done_cnt != 1) begin errors++; $display("FAIL busy_start_done got %0d exp 1", done_cnt); end
   endtask

   task automatic test_random();
      int nacc;
      bit ok;
      bit drv_done;
      int n;
      bit gap;
      for (int it = 0; it < 4; it++) begin
         n   = $urandom_range(1, 12);
         gap = 1'($urandom_range(0, 1));
         set_rows(n, 1'b1);
         clear_mon();
         start_coll(n);
         drv_done = 1'b0;
         fork
            begin
               drive_beats(n + 3, gap, nacc);
               drv_done = 1'b1;
            end
            begin
               while (!drv_done) begin
                  @(posedge clk); #1;
                  out_ready = 1'($urandom_range(0, 1));
               end
               out_ready = 1'b1;
            end
         join
         wait_done(ok);
         checks++; if (!ok) begin errors++; $display("FAIL rand%0d_done_timeout got 0 exp 1", it); end
         checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rand%0d_count got %0d exp %0d", it, got_q.size(), exp_q.size()); end
         for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand%0d_row%0d got %h exp %h", it, i, got_q[i], exp_q[i]); end
         end
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      start     = 1'b0;
      num_rows  = 8'd0;
      en        = 1'b0;
      d         = 32'h0;
      out_ready = 1'b1;
      cur_n     = 0;
      clear_mon();
      fork
         forever begin
            @(negedge clk);
            if (rst_n) begin
               if (en && in_rdy) beat_cyc.push_back(cyc);
               if (out_valid && out_ready) begin
                  got_q.push_back({out_last, out_data});
                  hs_cyc.push_back(cyc);
               end
               if (done) begin
                  done_cnt++;
                  done_cyc = cyc;
               end
            end
         end
      join_none
      test_reset();
      test_basic();
      test_backpressure();
      test_gapped();
      test_zero();
      test_reset_mid();
      test_start_busy();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
